cu_select_responder: RTL



---
 rtl/cu_select_responder.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/cu_select_responder.sv
// cu_select_responder
// Control-unit end of a parallel channel bus-and-tag interface. It answers the
// channel's initial selection sequence for one device address. It captures the
// command byte and presents the initial status byte, using the interlocked tag
// handshake. A selection that is not for this unit is passed from select_out
// through to select_in, as on a select chain.
//
// Ports
//   clk, reset_n            system clock, asynchronous active-low reset
//   bus_out, bus_out_parity channel Bus Out byte and its odd parity
//   *_out tags              channel outbound tags (suppress_out is unused)
//   bus_in, bus_in_parity   Bus In byte to the channel and its odd parity
//   *_in tags               inbound tags (request/data/disconnect are tied 0)
//   init_status             host status byte for the current command
//   cmd_valid, cmd          one-cycle accept pulse and the last accepted command
//   parity_err, timeout_err sticky error flags, cleared by err_clear
//
// state            | meaning
// IDLE             | waiting for a rising select_out with hold, operational and address out
// PROPAGATE        | selection is not ours; select_in follows select_out & hold_out
// WAIT_ADDR_DROP   | operational_in is raised; waiting for address_out to fall
// WAIT_CMD         | address_in is up with our address on bus_in; waiting for command_out
// WAIT_CMD_DROP    | command is latched; waiting for command_out to fall
// WAIT_ACCEPT      | status_in is up; waiting for service_out (accept) or command_out (stack)
// WAIT_ACCEPT_DROP | waiting for service_out and command_out both low before releasing
module cu_select_responder #(
    parameter logic [7:0] DEV_ADDR       = 8'h00,
    parameter int         SYNC_STAGES    = 2,
    parameter int         TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] bus_out,
    input  logic       bus_out_parity,
    input  logic       operational_out,
    input  logic       address_out,
    input  logic       select_out,
    input  logic       hold_out,
    input  logic       command_out,
    input  logic       service_out,
    input  logic       suppress_out,
    output logic [7:0] bus_in,
    output logic       bus_in_parity,
    output logic       operational_in,
    output logic       address_in,
    output logic       status_in,
    output logic       service_in,
    output logic       select_in,
    output logic       request_in,
    output logic       data_in,
    output logic       disconnect_in,
    input  logic [7:0] init_status,
    output logic       cmd_valid,
    output logic [7:0] cmd,
    output logic       parity_err,
    output logic       timeout_err,
    input  logic       err_clear
);

    localparam int SIN_W = 15;
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, PROPAGATE, WAIT_ADDR_DROP, WAIT_CMD,
        WAIT_CMD_DROP, WAIT_ACCEPT, WAIT_ACCEPT_DROP
    } state_t;

    logic unused_ok;
    assign unused_ok = suppress_out;

    // Every inbound cable signal goes through the same synchroniser depth.
    // Bus Out then stays aligned with the tags that qualify it.
    logic [SIN_W-1:0] sync_q [SYNC_STAGES];
    logic [7:0] bo_s;
    logic bop_s, op_s, ad_s, sel_s, hold_s, cm_s, sv_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= {bus_out, bus_out_parity, operational_out, address_out,
                          select_out, hold_out, command_out, service_out};
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    assign {bo_s, bop_s, op_s, ad_s, sel_s, hold_s, cm_s, sv_s} = sync_q[SYNC_STAGES-1];

    state_t         state_q, state_d;
    logic [TW-1:0]  tmr_q, tmr_d;
    logic [7:0]     bus_in_q, bus_in_d, cmd_q, cmd_d;
    logic           bin_par_q, bin_par_d;
    logic           opin_q, opin_d, adin_q, adin_d, stin_q, stin_d, selin_q, selin_d;
    logic           cmd_valid_q, cmd_valid_d;
    logic           perr_q, perr_d, terr_q, terr_d;
    logic           sel_prev_q;
    logic           par_ok, sel_rise, counting, timeout, perr_set, terr_set;

    assign par_ok   = ^{bo_s, bop_s};
    assign sel_rise = sel_s & ~sel_prev_q;
    assign counting = (state_q != IDLE) && (state_q != PROPAGATE);
    assign timeout  = counting && (tmr_q == '0);

    always_comb begin
        state_d     = state_q;
        opin_d      = opin_q;
        adin_d      = adin_q;
        stin_d      = stin_q;
        selin_d     = 1'b0;
        bus_in_d    = bus_in_q;
        cmd_d       = cmd_q;
        cmd_valid_d = 1'b0;
        perr_set    = 1'b0;
        terr_set    = 1'b0;

        if (!op_s || timeout) begin
            // A selective/system reset and an abandoned sequence both release the interface.
            terr_set = op_s;
            state_d  = IDLE;
            opin_d   = 1'b0;
            adin_d   = 1'b0;
            stin_d   = 1'b0;
            bus_in_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    selin_d = sel_s & hold_s;
                    if (sel_rise && hold_s && ad_s) begin
                        if (bo_s == DEV_ADDR && par_ok) begin
                            selin_d = 1'b0;
                            opin_d  = 1'b1;
                            state_d = WAIT_ADDR_DROP;
                        end else begin
                            perr_set = (bo_s == DEV_ADDR);
                            state_d  = PROPAGATE;
                        end
                    end
                end
                PROPAGATE: begin
                    selin_d = sel_s & hold_s;
                    if (!sel_s) state_d = IDLE;
                end
                WAIT_ADDR_DROP: if (!ad_s) begin
                    bus_in_d = DEV_ADDR;
                    adin_d   = 1'b1;
                    state_d  = WAIT_CMD;
                end
                WAIT_CMD: if (cm_s) begin
                    cmd_d       = bo_s;
                    cmd_valid_d = 1'b1;
                    perr_set    = ~par_ok;
                    adin_d      = 1'b0;
                    state_d     = WAIT_CMD_DROP;
                end
                WAIT_CMD_DROP: if (!cm_s) begin
                    bus_in_d = init_status;
                    stin_d   = 1'b1;
                    state_d  = WAIT_ACCEPT;
                end
                WAIT_ACCEPT: if (sv_s || cm_s) begin
                    stin_d  = 1'b0;
                    state_d = WAIT_ACCEPT_DROP;
                end
                WAIT_ACCEPT_DROP: if (!sv_s && !cm_s) begin
                    opin_d   = 1'b0;
                    bus_in_d = '0;
                    state_d  = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        // A new error in the same cycle as err_clear keeps the flag set.
        perr_d    = perr_set | (perr_q & ~err_clear);
        terr_d    = terr_set | (terr_q & ~err_clear);
        bin_par_d = ~^bus_in_d;

        if (state_d != state_q)       tmr_d = TMR_LOAD;
        else if (counting && !timeout) tmr_d = tmr_q - 1'b1;
        else                          tmr_d = tmr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tmr_q       <= TMR_LOAD;
            bus_in_q    <= '0;
            bin_par_q   <= 1'b1;
            opin_q      <= 1'b0;
            adin_q      <= 1'b0;
            stin_q      <= 1'b0;
            selin_q     <= 1'b0;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            perr_q      <= 1'b0;
            terr_q      <= 1'b0;
            sel_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            bus_in_q    <= bus_in_d;
            bin_par_q   <= bin_par_d;
            opin_q      <= opin_d;
            adin_q      <= adin_d;
            stin_q      <= stin_d;
            selin_q     <= selin_d;
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            perr_q      <= perr_d;
            terr_q      <= terr_d;
            sel_prev_q  <= sel_s;
        end
    end

    assign bus_in         = bus_in_q;
    assign bus_in_parity  = bin_par_q;
    assign operational_in = opin_q;
    assign address_in     = adin_q;
    assign status_in      = stin_q;
    assign service_in     = 1'b0;
    assign select_in      = selin_q;
    assign request_in     = 1'b0;
    assign data_in        = 1'b0;
    assign disconnect_in  = 1'b0;
    assign cmd_valid      = cmd_valid_q;
    assign cmd            = cmd_q;
    assign parity_err     = perr_q;
    assign timeout_err    = terr_q;

endmodule
